clk_en_gen: RTL and testbench

Parametrised multi-channel clock-enable generator for the VDP/VGA subsystem, replacing the hand-written fixed /4 and /20 toggle dividers on the 100 MHz fabric clock. It produces single-cycle enable strobes and matching 50%-duty toggle outputs per channel, all in the `clk` domain. Each channel has a runtime-writable divisor, applied glitch-free at that channel's next wrap. A global sync request phase-aligns all channels. Consumers (VGA timing, VDP, CPU cadence) run on `clk` qualified by `en[i]` instead of derived clocks.

---
 rtl/clk_en_pkg.sv | 18 +
 rtl/clk_en_ch.sv | 94 +++++++++
 rtl/clk_en_gen.sv | 46 ++++
 tb/tb_clk_en_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// Shared types and constants for the clk_en_gen clock-enable generator.
// Divisor defaults assume the 100 MHz fabric clock.
package clk_en_pkg;

  localparam int unsigned DIV_W_DEF = 8;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // 100 MHz / 4 = 25 MHz pixel cadence, 100 MHz / 10 = 10 MHz strobe (5 MHz square on tog)
  localparam div_t DIV_25M = div_t'(4);
  localparam div_t DIV_5M  = div_t'(10);

  // Channel-select width, never narrower than one bit
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_ch.sv
// One clock-enable channel: counter (or NCO accumulator when CLK_EN_GEN_FRAC_EN
// is defined), shadow divisor with glitch-free apply on wrap, en/tog/pend outputs.
module clk_en_ch
  import clk_en_pkg::*;
#(
  parameter int unsigned      DIV_W    = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_25M)
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_data,
  output logic             en,
  output logic             tog,
  output logic             pend
);

  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic [DIV_W-1:0] div_shd_q, div_shd_d;
  // Holds the up-counter, or the phase accumulator in the fractional build
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             tog_q, tog_d;
  logic             pend_q, pend_d;

  logic             fire;
  logic [DIV_W-1:0] cnt_next;

`ifdef CLK_EN_GEN_FRAC_EN
  logic [DIV_W:0] sum;

  assign sum      = {1'b0, cnt_q} + {1'b0, div_act_q};
  assign fire     = sum[DIV_W];
  assign cnt_next = sum[DIV_W-1:0];
`else
  logic [DIV_W-1:0] last;

  // A divisor of 0 behaves as 1, so the terminal count is 0 in both cases
  assign last     = (div_act_q == '0) ? '0 : div_act_q - DIV_W'(1);
  assign fire     = (cnt_q == last);
  assign cnt_next = fire ? '0 : cnt_q + DIV_W'(1);
`endif

  always_comb begin
    div_shd_d = wr ? wr_data : div_shd_q;
    div_act_d = div_act_q;
    cnt_d     = cnt_next;
    en_d      = fire;
    tog_d     = tog_q ^ fire;
    pend_d    = pend_q;

    // Apply takes the shadow as it was before this edge's write
    if (fire) begin
      div_act_d = div_shd_q;
      pend_d    = 1'b0;
    end
    if (wr) begin
      pend_d = 1'b1;
    end

    // Sync wins over wrap and also absorbs a write landing on the same edge
    if (sync) begin
      cnt_d     = '0;
      div_act_d = div_shd_d;
      en_d      = 1'b0;
      tog_d     = 1'b0;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      div_act_q <= DIV_INIT;
      div_shd_q <= DIV_INIT;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      tog_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      tog_q     <= tog_d;
      pend_q    <= pend_d;
    end
  end

  assign en   = en_q;
  assign tog  = tog_q;
  assign pend = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: per-channel strobes and 50% toggles on clk.
// Define CLK_EN_GEN_FRAC_EN to turn every channel into a fractional NCO.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int unsigned             NUM_CH   = 2,
  parameter int unsigned             DIV_W    = DIV_W_DEF,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {DIV_5M, DIV_25M}
) (
  input  logic                          clk,
  input  logic                          rst_L,
  input  logic                          div_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0]   div_ch,
  input  logic [DIV_W-1:0]              div_data,
  input  logic                          sync_req,
  output logic [NUM_CH-1:0]             en,
  output logic [NUM_CH-1:0]             tog,
  output logic [NUM_CH-1:0]             pend
);

  logic in_range;

  // Out-of-range channel numbers are dropped rather than aliased
  assign in_range = 32'(div_ch) < NUM_CH;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;

    assign wr_sel = div_wr && in_range && (32'(div_ch) == i);

    clk_en_ch #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT[i*DIV_W +: DIV_W])
    ) u_ch (
      .clk     (clk),
      .rst_L   (rst_L),
      .sync    (sync_req),
      .wr      (wr_sel),
      .wr_data (div_data),
      .en      (en[i]),
      .tog     (tog[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen (integer divide build): down-counter reference model feeds an
// expectation queue each edge; directed constant checks cover the key timing points.
module tb_clk_en_gen;

  localparam int unsigned             NUM_CH   = 3;
  localparam int unsigned             DIV_W    = 8;
  localparam logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd6, 8'd10, 8'd4};

  logic       clk = 1'b0;
  logic       rst_L = 1'b0;
  logic       div_wr = 1'b0;
  logic [1:0] div_ch = 2'd0;
  logic [7:0] div_data = 8'd0;
  logic       sync_req = 1'b0;
  logic [2:0] en, tog, pend;

  clk_en_gen #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .DIV_INIT (DIV_INIT)
  ) dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .div_wr   (div_wr),
    .div_ch   (div_ch),
    .div_data (div_data),
    .sync_req (sync_req),
    .en       (en),
    .tog      (tog),
    .pend     (pend)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] sb_q[$];

  int unsigned m_act [NUM_CH];
  int unsigned m_shd [NUM_CH];
  int unsigned m_rem [NUM_CH];
  logic [2:0]  m_en, m_tog, m_pend;

  function automatic int unsigned neff(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_act[i] = DIV_INIT[i*DIV_W +: DIV_W];
      m_shd[i] = m_act[i];
      m_rem[i] = neff(m_act[i]);
    end
    m_en   = '0;
    m_tog  = '0;
    m_pend = '0;
  endtask

  // Reference: remaining-cycles down-counter per channel
  task automatic model_edge(input logic s, input logic w, input logic [1:0] c,
                            input logic [7:0] d);
    for (int i = 0; i < NUM_CH; i++) begin
      logic sel;
      sel = w && (int'(c) == i);
      if (s) begin
        if (sel) m_shd[i] = d;
        m_act[i]  = m_shd[i];
        m_rem[i]  = neff(m_act[i]);
        m_en[i]   = 1'b0;
        m_tog[i]  = 1'b0;
        m_pend[i] = 1'b0;
      end else begin
        if (m_rem[i] == 1) begin
          m_en[i]   = 1'b1;
          m_tog[i]  = ~m_tog[i];
          m_act[i]  = m_shd[i];
          m_pend[i] = 1'b0;
          m_rem[i]  = neff(m_act[i]);
        end else begin
          m_en[i]  = 1'b0;
          m_rem[i] = m_rem[i] - 1;
        end
        if (sel) begin
          m_shd[i]  = d;
          m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp_v);
    n_tests++;
    assert (got === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed en/tog/pend=%b expected %b", tag, got, exp_v);
    end
  endtask

  task automatic check3(input string tag, input logic [2:0] got, input logic [2:0] exp_v);
    n_tests++;
    assert (got === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp_v);
    end
  endtask

  // One clock edge: predict, clock, then compare what the DUT produced
  task automatic step(input string tag);
    logic [8:0] e;
    model_edge(sync_req, div_wr, div_ch, div_data);
    sb_q.push_back({m_en, m_tog, m_pend});
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check(tag, {en, tog, pend}, e);
    #1;
  endtask

  task automatic write(input logic [1:0] c, input logic [7:0] d, input string tag);
    div_wr   = 1'b1;
    div_ch   = c;
    div_data = d;
    step(tag);
    div_wr   = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_state", {en, tog, pend}, 9'd0);
    @(negedge clk);
    #1;
    rst_L = 1'b1;

    // Defaults 4/10/6 from reset release
    for (int e = 1; e <= 21; e++) begin
      step("defaults");
      if (e == 3)  check3("no_en_before_4", en, 3'b000);
      if (e == 4)  check3("en0_edge4", en, 3'b001);
      if (e == 6)  check3("en2_edge6", en, 3'b100);
      if (e == 8)  check3("tog0_edge8", tog, 3'b100);
      if (e == 10) check3("en1_edge10", en, 3'b010);
      if (e == 12) check3("en_edge12", en, 3'b101);
      if (e == 20) check3("en_edge20", en, 3'b011);
    end

    // Edge 21 left ch0 at cnt=1: write 6, old period finishes first
    write(2'd0, 8'd6, "wr_ch0_6");
    check3("pend0_set", pend, 3'b001);
    for (int e = 1; e <= 14; e++) begin
      step("ch0_period6");
      if (e == 2)  check3("apply_edge_en", {en[0], pend[0], 1'b0}, 3'b100);
      if (e == 8)  check3("en0_6_apart", {2'b00, en[0]}, 3'b001);
      if (e == 14) check3("en0_12_apart", {2'b00, en[0]}, 3'b001);
    end

    // Divisors 0 and 1, plus back-to-back writes to ch1 (last wins)
    write(2'd0, 8'd0, "wr_ch0_0");
    write(2'd2, 8'd1, "wr_ch2_1");
    write(2'd1, 8'd7, "wr_ch1_7");
    write(2'd1, 8'd5, "wr_ch1_5");
    for (int e = 0; e < 24; e++) step("n0_n1_run");
    check3("n0_n1_en_high", {en[2], en[0], 1'b1}, 3'b111);

    // Pending ch0=4, then sync together with ch1=3
    write(2'd0, 8'd4, "wr_ch0_4");
    sync_req = 1'b1;
    div_wr   = 1'b1;
    div_ch   = 2'd1;
    div_data = 8'd3;
    step("sync_wr");
    sync_req = 1'b0;
    div_wr   = 1'b0;
    check("sync_clears", {en, tog, pend}, 9'd0);
    for (int e = 1; e <= 12; e++) begin
      step("after_sync");
      if (e == 3) check3("en1_plus3", en & 3'b011, 3'b010);
      if (e == 4) check3("en0_plus4", en & 3'b011, 3'b001);
    end

    // Sync held high keeps everything parked
    sync_req = 1'b1;
    for (int e = 0; e < 4; e++) step("sync_held");
    sync_req = 1'b0;
    for (int e = 0; e < 8; e++) step("after_held");

    // Out-of-range channel write is ignored
    write(2'd3, 8'd99, "wr_oor");
    check3("oor_no_pend", pend, 3'b000);
    for (int e = 0; e < 12; e++) step("after_oor");

    // Pending write then asynchronous reset mid-count
    write(2'd0, 8'd9, "wr_before_rst");
    step("pre_rst");
    rst_L = 1'b0;
    #1;
    check("async_rst", {en, tog, pend}, 9'd0);
    model_reset();
    @(negedge clk);
    #1;
    rst_L = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step("after_rst");
      if (e == 4) check3("init_restored", en, 3'b001);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
